// File: rtl/weight_stream_reader.sv
// weight_stream_reader
//   Burst reader for the managed weight memory. A start request latches a first
//   row and a row count; the block then issues one-row reads over the memory's
//   control port and streams the returned words to the compute datapath on a
//   valid/ready interface. A small output FIFO with credit-based issue absorbs
//   the one-cycle synchronous read latency and downstream back-pressure. New
//   reads are held off while the SPI side owns the memory.
//
// Ports
//   clk, rst                     rising-edge clock, synchronous active-high reset
//   start, start_address, length burst request (sampled only when idle)
//   spi_active                   SPI owns the memory; blocks new reads
//   busy, done                   burst in progress / one-cycle completion pulse
//   weight_control_*             memory control port (read-only use)
//   weight_data_out              memory read data, valid the cycle after a read
//   out_valid, out_ready,
//   out_data                     output stream (FIFO head)
module weight_stream_reader #(
  parameter int WEIGHT_WORD_BIT_WIDTH = 64,
  parameter int WEIGHT_ROWS           = 32,
  parameter int FIFO_DEPTH            = 2,
  localparam int WEIGHT_ADDRESS_WIDTH = $clog2(WEIGHT_ROWS),
  localparam int LENGTH_WIDTH         = $clog2(WEIGHT_ROWS + 1)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  input  logic [WEIGHT_ADDRESS_WIDTH-1:0]  start_address,
  input  logic [LENGTH_WIDTH-1:0]          length,
  input  logic                             spi_active,
  output logic                             busy,
  output logic                             done,
  output logic                             weight_control_chip_select,
  output logic                             weight_control_write_enable,
  output logic [WEIGHT_ADDRESS_WIDTH-1:0]  weight_control_address,
  output logic [WEIGHT_WORD_BIT_WIDTH-1:0] weight_control_data_in,
  output logic [WEIGHT_WORD_BIT_WIDTH-1:0] weight_control_mask,
  input  logic [WEIGHT_WORD_BIT_WIDTH-1:0] weight_data_out,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [WEIGHT_WORD_BIT_WIDTH-1:0] out_data
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int OCC_W = CNT_W + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t                          state_q;
  logic [WEIGHT_ADDRESS_WIDTH-1:0] addr_q;
  logic [LENGTH_WIDTH-1:0]         issue_left_q;
  logic [LENGTH_WIDTH-1:0]         deliver_left_q;
  logic                            vld_p1;
  logic [PTR_W-1:0]                wr_ptr_q;
  logic [PTR_W-1:0]                rd_ptr_q;
  logic [CNT_W-1:0]                fifo_count_q;
  logic [WEIGHT_WORD_BIT_WIDTH-1:0] fifo_mem [FIFO_DEPTH];

  logic             issue_p0;
  logic             push;
  logic             pop;
  logic [OCC_W-1:0] occupancy;

  // Stage p0: issue decision. A word popped this cycle frees its slot now, so
  // steady-state streaming sustains one read per cycle with only two entries.
  always_comb begin
    pop       = (fifo_count_q != '0) && out_ready;
    push      = vld_p1;
    occupancy = OCC_W'(fifo_count_q) + OCC_W'(vld_p1) - OCC_W'(pop);
    issue_p0  = (state_q == RUN) && (issue_left_q != '0) && !spi_active &&
                (occupancy < OCC_W'(FIFO_DEPTH));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      addr_q         <= '0;
      issue_left_q   <= '0;
      deliver_left_q <= '0;
      vld_p1         <= 1'b0;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      fifo_count_q   <= '0;
    end else begin
      vld_p1       <= issue_p0;
      fifo_count_q <= fifo_count_q + CNT_W'(push) - CNT_W'(pop);
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop) begin
        rd_ptr_q       <= rd_ptr_q + PTR_W'(1);
        deliver_left_q <= deliver_left_q - LENGTH_WIDTH'(1);
      end
      if (issue_p0) begin
        addr_q       <= (addr_q == WEIGHT_ADDRESS_WIDTH'(WEIGHT_ROWS - 1)) ?
                        '0 : addr_q + WEIGHT_ADDRESS_WIDTH'(1);
        issue_left_q <= issue_left_q - LENGTH_WIDTH'(1);
      end
      unique case (state_q)
        IDLE: begin
          if (start) begin
            addr_q         <= start_address;
            issue_left_q   <= length;
            deliver_left_q <= length;
            // A zero-length burst spends one cycle in DRAIN (nothing to wait
            // for), which places its done pulse two cycles after start.
            state_q        <= (length == '0) ? DRAIN : RUN;
          end
        end
        RUN: begin
          if (issue_left_q == '0) state_q <= DRAIN;
        end
        DRAIN: begin
          // Finish in the cycle after the last word leaves, not one later.
          if ((deliver_left_q == '0) ||
              ((deliver_left_q == LENGTH_WIDTH'(1)) && pop))
            state_q <= DONE;
        end
        DONE: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Stage p1: capture. Memory output reflects the read issued last cycle; an
  // SPI access starting now only changes it after this edge.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= weight_data_out;
  end

  assign busy                        = !rst && ((state_q == RUN) || (state_q == DRAIN));
  assign done                        = !rst && (state_q == DONE);
  assign weight_control_chip_select  = !rst && issue_p0;
  assign weight_control_write_enable = 1'b0;
  assign weight_control_address      = rst ? '0 : addr_q;
  assign weight_control_data_in      = '0;
  assign weight_control_mask         = '0;
  assign out_valid                   = !rst && (fifo_count_q != '0);
  assign out_data                    = out_valid ? fifo_mem[rd_ptr_q] : '0;

endmodule

// File: tb/tb_weight_stream_reader.sv
module tb_weight_stream_reader;

  localparam int W     = 64;
  localparam int ROWS  = 32;
  localparam int DEPTH = 2;
  localparam int AW    = $clog2(ROWS);
  localparam int LW    = $clog2(ROWS + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] start_address;
  logic [LW-1:0] length;
  logic          spi_active;
  logic          busy;
  logic          done;
  logic          cs;
  logic          we;
  logic [AW-1:0] address;
  logic [W-1:0]  data_in;
  logic [W-1:0]  mask;
  logic [W-1:0]  weight_data_out;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;

  int vectors     = 0;
  int miscompares = 0;

  logic [W-1:0] weight_mem [ROWS];

  always #5 clk = ~clk;

  weight_stream_reader #(
    .WEIGHT_WORD_BIT_WIDTH(W),
    .WEIGHT_ROWS(ROWS),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .start_address(start_address),
    .length(length),
    .spi_active(spi_active),
    .busy(busy),
    .done(done),
    .weight_control_chip_select(cs),
    .weight_control_write_enable(we),
    .weight_control_address(address),
    .weight_control_data_in(data_in),
    .weight_control_mask(mask),
    .weight_data_out(weight_data_out),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data)
  );

  // Synchronous memory: data appears the cycle after the read strobe.
  always @(posedge clk) begin
    if (cs) weight_data_out <= weight_mem[address];
  end

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    int sa;
    int len;
    int ready_mode;  // 0 always, 1 pattern 1,0,0,1, 2 random
    int spi_mode;    // 0 never, 1 window [spi_lo,spi_hi], 2 random
    int spi_lo;
    int spi_hi;
    int restart_c;   // cycle of an extra start pulse that must be ignored
    int exp_first;   // expected first-accept cycle, -1 = don't care
    int exp_done;    // expected done cycle, -1 = don't care
  } vec_t;

  // Reference: the burst must deliver weight_mem[(sa+i) mod ROWS] for
  // i = 0..len-1 in order, reading exactly those addresses, never more than
  // DEPTH words outstanding, and never reading while SPI owns the memory.
  task automatic run_burst(input vec_t v);
    int issued, accepted, done_c, first_c;
    issued = 0; accepted = 0; done_c = -1; first_c = -1;
    for (int c = 0; c < 400 && done_c < 0; c++) begin
      start         = (c == 0) || (c == v.restart_c);
      start_address = (c == 0) ? AW'(v.sa) : AW'((v.sa + 9) % ROWS);
      length        = (c == 0) ? LW'(v.len) : LW'(1);
      case (v.ready_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = ((c % 4) == 0) || ((c % 4) == 3);
        default: out_ready = ($urandom_range(0, 3) != 0);
      endcase
      case (v.spi_mode)
        0:       spi_active = 1'b0;
        1:       spi_active = (c >= v.spi_lo) && (c <= v.spi_hi);
        default: spi_active = ($urandom_range(0, 3) == 0);
      endcase
      @(negedge clk);
      if (cs) begin
        chk("issue_while_spi", W'(spi_active), W'(0));
        chk("issue_addr", W'(address), W'((v.sa + issued) % ROWS));
        chk("issue_extra", W'(issued < v.len), W'(1));
        issued++;
      end
      if (out_valid && out_ready) begin
        if (first_c < 0) first_c = c;
        chk("data", out_data, weight_mem[(v.sa + accepted) % ROWS]);
        accepted++;
      end
      chk("credit", W'((issued - accepted) <= DEPTH), W'(1));
      chk("busy", W'(busy), W'((c >= 1) && !done));
      if (done) begin
        done_c = c;
        chk("done_count", W'(accepted), W'(v.len));
        if (v.exp_done >= 0) chk("done_cycle", W'(c), W'(v.exp_done));
      end
      @(posedge clk); #1;
    end
    start = 1'b0; spi_active = 1'b0; out_ready = 1'b1;
    if (done_c < 0) begin
      vectors++; miscompares++;
      $display("FAIL done_timeout: got no done expected done within 400 cycles");
    end
    if (v.exp_first >= 0) chk("first_valid_cycle", W'(first_c), W'(v.exp_first));
    @(negedge clk);
    chk("post_busy", W'(busy), W'(0));
    chk("post_done", W'(done), W'(0));
    chk("post_cs", W'(cs), W'(0));
    @(posedge clk); #1;
  endtask

  vec_t table_v [6];

  initial begin
    for (int r = 0; r < ROWS; r++) weight_mem[r] = 64'h1000 + 64'(r);
    weight_data_out = '0;
    rst = 1'b1; start = 1'b0; start_address = '0; length = '0;
    spi_active = 1'b0; out_ready = 1'b1;

    //            sa  len rdy spi lo hi  rst  first done
    table_v[0] = '{2,  4,  0,  0, 0, 0,  2,   3,    7};   // basic + start while busy
    table_v[1] = '{30, 4,  0,  0, 0, 0,  7,   3,    7};   // wrap + start in DONE
    table_v[2] = '{5,  6,  1,  0, 0, 0,  -1,  -1,   -1};  // back-pressure
    table_v[3] = '{10, 5,  0,  1, 2, 5,  -1,  -1,   -1};  // SPI contention
    table_v[4] = '{7,  0,  0,  0, 0, 0,  1,   -1,   2};   // zero length
    table_v[5] = '{0,  32, 0,  0, 0, 0,  -1,  3,    35};  // full memory

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", W'(busy), W'(0));
    chk("rst_done", W'(done), W'(0));
    chk("rst_cs", W'(cs), W'(0));
    chk("rst_addr", W'(address), W'(0));
    chk("rst_valid", W'(out_valid), W'(0));
    chk("rst_data", out_data, W'(0));
    chk("tie_we", W'(we), W'(0));
    chk("tie_din", data_in, W'(0));
    chk("tie_mask", mask, W'(0));
    @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < 6; i++) run_burst(table_v[i]);

    // Reset in cycle 4 of a length-8 burst.
    start = 1'b1; start_address = AW'(3); length = LW'(8); out_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("midrst_busy", W'(busy), W'(0));
    chk("midrst_cs", W'(cs), W'(0));
    chk("midrst_valid", W'(out_valid), W'(0));
    chk("midrst_data", out_data, W'(0));
    chk("midrst_addr", W'(address), W'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk("after_rst_busy", W'(busy), W'(0));
      chk("after_rst_done", W'(done), W'(0));
      chk("after_rst_cs", W'(cs), W'(0));
      chk("after_rst_valid", W'(out_valid), W'(0));
      @(posedge clk); #1;
    end
    run_burst('{12, 3, 0, 0, 0, 0, -1, 3, 6});

    // Randomized bursts with random back-pressure and SPI contention.
    for (int k = 0; k < 20; k++) begin
      for (int r = 0; r < ROWS; r++) weight_mem[r] = {$urandom, $urandom};
      run_burst('{$urandom_range(0, ROWS - 1), $urandom_range(0, ROWS),
                  2, 2, 0, 0, $urandom_range(1, 10), -1, -1});
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
